// File: rtl/riscv_pkg.sv
// riscv_pkg: immediate-format selects and encoder FSM state shared by the encoder files
package riscv_pkg;
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;
  localparam logic [2:0] IMM_R = 3'b111;
  typedef enum logic [1:0] {IDLE, RUN, ERR} enc_state_t;
endpackage

// File: rtl/imm_encoder_if.sv
// imm_encoder_if: request fields in, imem write port out; slave is the encoder side
interface imm_encoder_if #(parameter int ADDR_W = 32);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        immsrc;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [31:0]       imm;
  logic              wr_en;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [15:0]       count;
  logic              err;
  modport master (
    output start, base_addr, in_valid, immsrc, opcode, funct3, funct7, rd, rs1, rs2, imm, wr_ready,
    input  in_ready, wr_en, wr_addr, wr_data, count, err
  );
  modport slave (
    input  start, base_addr, in_valid, immsrc, opcode, funct3, funct7, rd, rs1, rs2, imm, wr_ready,
    output in_ready, wr_en, wr_addr, wr_data, count, err
  );
endinterface

// File: rtl/imm_pack.sv
// imm_pack: packs decoded fields into an RV32I word; range flag only with IMM_RANGE_CHECK_EN
module imm_pack
  import riscv_pkg::*;
(
  input  logic [2:0]  immsrc,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal,
  output logic        range_err
);
  always_comb begin
    word = immsrc == IMM_I ? {imm[11:0], rs1, funct3, rd, opcode} :
           immsrc == IMM_S ? {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode} :
           immsrc == IMM_B ? {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode} :
           immsrc == IMM_U ? {imm[31:12], rd, opcode} :
           immsrc == IMM_J ? {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode} :
                             {funct7, rs2, rs1, funct3, rd, opcode};
    illegal = immsrc == 3'b101 || immsrc == 3'b110;
  end
`ifdef IMM_RANGE_CHECK_EN
  logic sx11, sx12, sx20;
  assign sx11 = &imm[31:11] || ~|imm[31:11];
  assign sx12 = &imm[31:12] || ~|imm[31:12];
  assign sx20 = &imm[31:20] || ~|imm[31:20];
  assign range_err = (immsrc == IMM_I || immsrc == IMM_S) ? !sx11 :
                     immsrc == IMM_B ? !sx12 || imm[0] :
                     immsrc == IMM_J ? !sx20 || imm[0] :
                     immsrc == IMM_U ? |imm[11:0] : 1'b0;
`else
  assign range_err = 1'b0;
`endif
endmodule

// File: rtl/imm_encoder.sv
// imm_encoder: streams packed RV32I words into imem from a loadable base address
// Optional immediate range checking is enabled by defining IMM_RANGE_CHECK_EN.
module imm_encoder
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input logic         clk,
  input logic         reset,
  imm_encoder_if.slave bus
);
  enc_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       count_q, count_d;
  logic              err_q, err_d, wr_en_q, wr_en_d;
  logic [31:0]       wr_data_q, wr_data_d, word;
  logic              illegal, range_err, done, accept;
  imm_pack u_pack (
    .immsrc(bus.immsrc), .opcode(bus.opcode), .funct3(bus.funct3), .funct7(bus.funct7),
    .rd(bus.rd), .rs1(bus.rs1), .rs2(bus.rs2), .imm(bus.imm),
    .word(word), .illegal(illegal), .range_err(range_err)
  );
  assign bus.in_ready = state_q == RUN && (!wr_en_q || bus.wr_ready);
  assign done         = wr_en_q && bus.wr_ready;
  assign accept       = bus.in_valid && bus.in_ready && !bus.start;
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    count_d   = count_q;
    err_d     = err_q;
    wr_en_d   = wr_en_q;
    wr_data_d = wr_data_q;
    if (bus.start) begin
      state_d   = RUN;
      addr_d    = bus.base_addr;
      count_d   = '0;
      err_d     = 1'b0;
      wr_en_d   = 1'b0;
      wr_data_d = '0;
    end else begin
      if (done) begin
        addr_d  = addr_q + ADDR_W'(1);
        count_d = count_q + {15'd0, ~&count_q};
        wr_en_d = 1'b0;
      end
      // a rejected request never reaches the output register
      if (accept && (illegal || range_err)) begin
        err_d   = 1'b1;
        state_d = ERR;
      end else if (accept) begin
        wr_en_d   = 1'b1;
        wr_data_d = word;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      err_q     <= err_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
    end
  end
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.count   = count_q;
  assign bus.err     = err_q;
endmodule

// File: doc/imm_encoder.md
# imm_encoder

Streaming instruction encoder, the inverse of the immediate-extension path. It accepts decoded instruction fields (opcode, registers, funct codes, a 32-bit immediate and the same 3-bit immediate-format select the decoder uses) and packs them into 32-bit RV32I instruction words. It writes the packed words sequentially into the instruction-memory write port from a loadable base address. The boot/self-test loader uses it to build programs in imem, and the testbench uses it as a golden encoder against the extender.

## Interface
- `ADDR_W`, default 32: width of the imem word address.
- `clk` input 1: clock.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: pulse; loads `base_addr`, clears count and error, enters RUN.
- `base_addr` input ADDR_W: first word address written.
- `in_valid` input 1: request fields valid.
- `in_ready` output 1: encoder accepts this cycle.
- `immsrc` input 3: 000 I, 001 S, 010 B, 011 U, 100 J, 111 R (no immediate); 101/110 are illegal.
- `opcode` input 7, `funct3` input 3, `funct7` input 7, `rd`/`rs1`/`rs2` input 5 each: instruction fields.
- `imm` input 32: immediate as the extender would output it.
- `wr_en` output 1: write valid.
- `wr_ready` input 1: imem accepts the write.
- `wr_addr` output ADDR_W, `wr_data` output 32: write address and packed word.
- `count` output 16: words written since `start`; saturates at 0xFFFF.
- `err` output 1: sticky format/range error.

## Operation
- States:
  - IDLE: `in_ready`=0. `start` moves to RUN.
  - RUN: normal encoding.
  - ERR: `in_ready`=0, `wr_en` drains any held word. Only `start` or `reset` leaves ERR.
- `start` in any state: addr←`base_addr`, count←0, err←0, output register cleared, next state RUN. In-flight words are discarded.
- Packing by format:
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - U: {imm[31:12], rd, opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
- Illegal `immsrc` (101/110) always sets err and moves to ERR. The word is not written.
- One-entry output register (`wr_en`/`wr_addr`/`wr_data`). `in_ready` = (state==RUN) && (!wr_en || wr_ready).
- A write completes on `wr_en && wr_ready`. On completion: addr+1 (wraps modulo 2^ADDR_W), count+1 (saturating).
- Simultaneous completion and accept is legal; the register reloads the same cycle with no bubble.
- `wr_data`/`wr_addr` stay stable while `wr_en && !wr_ready`.

## Timing
- Reset values: state IDLE, `in_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `count`=0, `err`=0.
- Latency: a request accepted in cycle N appears on `wr_en`/`wr_data` in cycle N+1.
- Throughput: 1 word/cycle while `wr_ready`=1.
- `err` asserts in the cycle after the offending accept. ERR is entered in the same edge.
- `reset` mid-stream drops the held word with no write. `start` has priority over `in_valid` in the same cycle; that request is not accepted.

## Configuration
- `IMM_RANGE_CHECK_EN` defined:
  - Reject and set err/ERR when the immediate is not representable:
    - I/S: imm must sign-extend from bit 11.
    - B: sign-extends from bit 12, imm[0]=0.
    - J: sign-extends from bit 20, imm[0]=0.
    - U: imm[11:0]=0.
  - A rejected word is not written.
- Undefined: no range checking. Out-of-range bits are silently truncated per the packing above. Only illegal `immsrc` errors.

## Structure
- Shared package `riscv_pkg`:
  - immsrc localparams IMM_I/IMM_S/IMM_B/IMM_U/IMM_J/IMM_R.
  - `enc_state_t` enum (IDLE, RUN, ERR).
- Sub-module `imm_pack`: combinational field packer plus range-check flag (flag under the macro). The top holds the FSM, output register, address and count.

## Test plan
- `start` base 0x40; I, opcode 0x13, rd 5, rs1 0, f3 0, imm 0xFFFFFFFF -> next cycle `wr_en`=1, addr 0x40, data 0xFFF00293; count 1.
- S, opcode 0x23, f3 2, rs1 1, rs2 2, imm 8, then U, opcode 0x37, rd 1, imm 0x12345000 -> 0x0020A423 @base, 0x123450B7 @base+1, back-to-back with `wr_ready`=1.
- J, opcode 0x6F, rd 0, imm 0xFFFFFFFC -> 0xFFDFF06F; hold `wr_ready`=0 3 cycles -> data/addr stable, `in_ready`=0, count unchanged until accept.
- With macro: B, imm 4096 -> err=1, ERR, no write; then imm 3 after `start` -> err again. Without macro: same B imm 4096 -> write occurs, err=0.
- immsrc 101 -> err=1 in both builds; `start` clears err, count=0, addr=new base.
- base 0xFFFFFFFF, two writes -> addrs 0xFFFFFFFF then 0x00000000. `reset` while `wr_en`=1 -> all outputs zero next cycle, no write.
